// File: rtl/core_io.sv
// Engine I/O core: 4x16-word input slot buffer with round-robin block dispatch,
// plus an 8-word result buffer streamed back to the engine. Optional sticky err via CORE_IO_ERR_EN.
module core_io #(
  parameter int MEM_WIDTH = 64,
  parameter int BLK_OP_W  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  // engine-side input word write
  input  logic                 wr_en,
  input  logic [3:0]           wr_addr,
  input  logic [MEM_WIDTH-1:0] din,
  input  logic                 input_ctx,
  input  logic                 input_seq,
  input  logic                 set_input_ready,
  input  logic [BLK_OP_W-1:0]  blk_op,
  output logic [3:0]           ready,
  // block dispatch
  output logic                 blk_valid,
  output logic [1:0]           blk_slot,
  output logic [BLK_OP_W-1:0]  blk_op_out,
  input  logic                 blk_ack,
  input  logic [3:0]           blk_rd_addr,
  output logic [MEM_WIDTH-1:0] blk_rd_data,
  input  logic                 blk_done,
  // result write
  input  logic                 res_wr_en,
  input  logic [2:0]           res_wr_addr,
  input  logic [MEM_WIDTH-1:0] res_din,
  input  logic                 res_commit,
  input  logic                 res_ctx,
  input  logic                 res_seq,
  output logic                 res_ready,
  // result return
  output logic                 dout_en,
  output logic                 dout_seq_num,
  output logic                 dout_ctx_num,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [3:0]          r_ready;
  logic [3:0]          w_ready_next;
  logic [BLK_OP_W-1:0] r_op [4];
  logic [1:0]          r_cur_slot;
  logic [1:0]          w_cur_slot_next;
  logic [1:0]          r_last_served;

  logic [MEM_WIDTH-1:0] r_in_mem [64];
  logic [MEM_WIDTH-1:0] r_blk_rd_data;

  logic [1:0] w_wr_slot;
  logic       w_wr_ok;
  logic       w_set_ok;
  logic       w_done_ok;

  assign w_wr_slot = {input_ctx, input_seq};
  assign w_wr_ok   = wr_en & r_ready[w_wr_slot];
  assign w_set_ok  = set_input_ready & r_ready[w_wr_slot];
  assign w_done_ok = blk_done & (r_state == ST_BUSY);

  // Slot ready flags. A busy slot always has ready=0, so a same-cycle set on it is dropped.
  always_comb begin
    w_ready_next = r_ready;
    if (w_set_ok) begin
      w_ready_next[w_wr_slot] = 1'b0;
    end
    if (w_done_ok) begin
      w_ready_next[r_cur_slot] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ready <= 4'b1111;
    end else begin
      r_ready <= w_ready_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        r_op[i] <= '0;
      end
    end else if (w_set_ok) begin
      r_op[w_wr_slot] <= blk_op;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_ok) begin
      r_in_mem[{w_wr_slot, wr_addr}] <= din;
    end
    r_blk_rd_data <= r_in_mem[{r_cur_slot, blk_rd_addr}];
  end

  // Round-robin candidates, nearest-after-last_served first.
  logic [3:0][1:0] w_cand;
  logic [3:0]      w_full;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign w_cand[gi] = r_last_served + 2'(gi + 1);
      assign w_full[gi] = ~r_ready[w_cand[gi]];
    end
  endgenerate

  logic       w_pick_valid;
  logic [1:0] w_pick_slot;

  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_slot  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_full[k]) begin
        w_pick_valid = 1'b1;
        w_pick_slot  = w_cand[k];
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cur_slot_next = r_cur_slot;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_next    = ST_OFFER;
          w_cur_slot_next = w_pick_slot;
        end
      end
      ST_OFFER: begin
        if (blk_ack) begin
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (blk_done) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_cur_slot    <= 2'd0;
      r_last_served <= 2'd3;
    end else begin
      r_state    <= w_state_next;
      r_cur_slot <= w_cur_slot_next;
      if (w_done_ok) begin
        r_last_served <= r_cur_slot;
      end
    end
  end

  assign ready       = r_ready;
  assign blk_valid   = (r_state == ST_OFFER);
  assign blk_slot    = r_cur_slot;
  assign blk_op_out  = r_op[r_cur_slot];
  assign blk_rd_data = r_blk_rd_data;

  // Result path: SEND streams words 0..7, prefetching the next word each cycle.
  logic [MEM_WIDTH-1:0] r_out_mem [8];
  logic [MEM_WIDTH-1:0] r_dout;
  logic                 r_send;
  logic [2:0]           r_send_idx;
  logic                 r_res_ready;
  logic                 r_dout_ctx;
  logic                 r_dout_seq;
  logic [2:0]           w_out_rd_addr;
  logic                 w_commit_ok;

  assign w_commit_ok   = res_commit & r_res_ready;
  assign w_out_rd_addr = r_send ? (r_send_idx + 3'd1) : 3'd0;

  always_ff @(posedge CLK) begin
    if (res_wr_en && r_res_ready) begin
      r_out_mem[res_wr_addr] <= res_din;
    end
    r_dout <= r_out_mem[w_out_rd_addr];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_send      <= 1'b0;
      r_send_idx  <= 3'd0;
      r_res_ready <= 1'b1;
      r_dout_ctx  <= 1'b0;
      r_dout_seq  <= 1'b0;
    end else if (r_send) begin
      if (r_send_idx == 3'd7) begin
        r_send      <= 1'b0;
        r_res_ready <= 1'b1;
      end else begin
        r_send_idx <= r_send_idx + 3'd1;
      end
    end else if (w_commit_ok) begin
      r_send      <= 1'b1;
      r_send_idx  <= 3'd0;
      r_res_ready <= 1'b0;
      r_dout_ctx  <= res_ctx;
      r_dout_seq  <= res_seq;
    end
  end

  assign res_ready    = r_res_ready;
  assign dout_en      = r_send;
  assign dout         = r_dout;
  assign dout_ctx_num = r_dout_ctx;
  assign dout_seq_num = r_dout_seq;

`ifdef CORE_IO_ERR_EN
  logic r_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if ((wr_en & ~r_ready[w_wr_slot]) |
                 (set_input_ready & ~r_ready[w_wr_slot]) |
                 (res_commit & ~r_res_ready)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_core_io.sv
// Directed bench for core_io: slot fill/dispatch, round-robin order, drops, result streaming, reset.
module tb_core_io;

`ifdef CORE_IO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [63:0] din = '0;
  logic        input_ctx = 1'b0;
  logic        input_seq = 1'b0;
  logic        set_input_ready = 1'b0;
  logic [1:0]  blk_op = '0;
  logic [3:0]  ready;
  logic        blk_valid;
  logic [1:0]  blk_slot;
  logic [1:0]  blk_op_out;
  logic        blk_ack = 1'b0;
  logic [3:0]  blk_rd_addr = '0;
  logic [63:0] blk_rd_data;
  logic        blk_done = 1'b0;
  logic        res_wr_en = 1'b0;
  logic [2:0]  res_wr_addr = '0;
  logic [63:0] res_din = '0;
  logic        res_commit = 1'b0;
  logic        res_ctx = 1'b0;
  logic        res_seq = 1'b0;
  logic        res_ready;
  logic        dout_en;
  logic        dout_seq_num;
  logic        dout_ctx_num;
  logic [63:0] dout;
  logic        err;

  int n_vec  = 0;
  int n_miss = 0;

  core_io #(.MEM_WIDTH(64), .BLK_OP_W(2)) dut (
    .CLK(CLK), .RST(RST),
    .wr_en(wr_en), .wr_addr(wr_addr), .din(din),
    .input_ctx(input_ctx), .input_seq(input_seq),
    .set_input_ready(set_input_ready), .blk_op(blk_op), .ready(ready),
    .blk_valid(blk_valid), .blk_slot(blk_slot), .blk_op_out(blk_op_out), .blk_ack(blk_ack),
    .blk_rd_addr(blk_rd_addr), .blk_rd_data(blk_rd_data), .blk_done(blk_done),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_din(res_din),
    .res_commit(res_commit), .res_ctx(res_ctx), .res_seq(res_seq), .res_ready(res_ready),
    .dout_en(dout_en), .dout_seq_num(dout_seq_num), .dout_ctx_num(dout_ctx_num), .dout(dout),
    .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic set_slot(input logic [1:0] s, input logic [1:0] op);
    input_ctx       = s[1];
    input_seq       = s[0];
    blk_op          = op;
    set_input_ready = 1'b1;
    tick();
    set_input_ready = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_ready", ready, 4'b1111);
    check("rst_blk_valid", blk_valid, 0);
    check("rst_res_ready", res_ready, 1);
    check("rst_dout_en", dout_en, 0);
    check("rst_dout_seq", dout_seq_num, 0);
    check("rst_dout_ctx", dout_ctx_num, 0);
    check("rst_err", err, 0);

    // fill slot 2 and dispatch it
    input_ctx = 1'b1;
    input_seq = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      din     = 64'h2000 + 64'(i);
      tick();
    end
    wr_en = 1'b0;
    set_slot(2'd2, 2'b10);
    check("s2_ready_after_set", ready, 4'b1011);
    check("s2_valid_1cyc", blk_valid, 0);
    tick();
    check("s2_valid_2cyc", blk_valid, 1);
    check("s2_slot", blk_slot, 2);
    check("s2_op", blk_op_out, 2'b10);
    tick();
    check("s2_valid_held", blk_valid, 1);
    check("s2_slot_held", blk_slot, 2);
    blk_ack = 1'b1;
    tick();
    blk_ack = 1'b0;
    check("s2_busy_valid", blk_valid, 0);
    wr_en = 1'b1; wr_addr = 4'd5; din = 64'hDEAD;
    tick();
    wr_en = 1'b0;
    check("drop_wr_err", err, ERR_EN);
    blk_rd_addr = 4'd5;
    tick();
    check("s2_rd5", blk_rd_data, 64'h2005);
    blk_rd_addr = 4'd15;
    tick();
    check("s2_rd15", blk_rd_data, 64'h200F);
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
    check("s2_done_ready", ready, 4'b1111);
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
    check("done_idle_ignored", ready, 4'b1111);

    // round-robin order 1, 3, 0 with last_served=0
    do_reset();
    set_slot(2'd0, 2'b01);
    tick();
    check("rr_first_slot", blk_slot, 0);
    blk_ack = 1'b1; tick(); blk_ack = 1'b0;
    set_slot(2'd1, 2'b11);
    set_slot(2'd3, 2'b00);
    check("rr_ready_filled", ready, 4'b0100);
    blk_done = 1'b1; tick(); blk_done = 1'b0;
    check("rr_s0_freed", ready, 4'b0101);
    set_slot(2'd0, 2'b10);
    check("rr_pick1_valid", blk_valid, 1);
    check("rr_pick1_slot", blk_slot, 1);
    check("rr_pick1_op", blk_op_out, 2'b11);
    check("rr_s0_refilled", ready, 4'b0100);
    blk_ack = 1'b1; tick(); blk_ack = 1'b0;
    blk_done = 1'b1; tick(); blk_done = 1'b0;
    check("rr_s1_freed", ready, 4'b0110);
    tick();
    check("rr_pick3_slot", blk_slot, 3);
    check("rr_pick3_op", blk_op_out, 2'b00);
    blk_ack = 1'b1; tick(); blk_ack = 1'b0;
    blk_done = 1'b1; tick(); blk_done = 1'b0;
    check("rr_s3_freed", ready, 4'b1110);
    tick();
    check("rr_pick0_valid", blk_valid, 1);
    check("rr_pick0_slot", blk_slot, 0);
    check("rr_pick0_op", blk_op_out, 2'b10);
    blk_ack = 1'b1; tick(); blk_ack = 1'b0;
    blk_done = 1'b1; tick(); blk_done = 1'b0;
    check("rr_all_free", ready, 4'b1111);

    // dropped set_input_ready on a full slot
    do_reset();
    check("err_clear", err, 0);
    set_slot(2'd1, 2'b01);
    check("dup_ready", ready, 4'b1101);
    set_slot(2'd1, 2'b10);
    check("dup_err", err, ERR_EN);
    check("dup_slot", blk_slot, 1);
    check("dup_op_kept", blk_op_out, 2'b01);
    tick();
    check("dup_err_sticky", err, ERR_EN);
    check("dup_op_kept2", blk_op_out, 2'b01);
    blk_ack = 1'b1; tick(); blk_ack = 1'b0;
    blk_done = 1'b1; tick(); blk_done = 1'b0;

    // same-cycle blk_done and set_input_ready on the busy slot
    do_reset();
    set_slot(2'd1, 2'b01);
    tick();
    blk_ack = 1'b1; tick(); blk_ack = 1'b0;
    check("coll_err_pre", err, 0);
    blk_done = 1'b1;
    set_slot(2'd1, 2'b11);
    blk_done = 1'b0;
    check("coll_ready", ready, 4'b1111);
    check("coll_err", err, ERR_EN);
    check("coll_valid", blk_valid, 0);
    tick();
    check("coll_ready2", ready, 4'b1111);
    check("coll_valid2", blk_valid, 0);

    // result stream with a concurrent dispatch
    do_reset();
    for (int i = 0; i < 8; i++) begin
      res_wr_en   = 1'b1;
      res_wr_addr = 3'(i);
      res_din     = 64'(i);
      tick();
    end
    res_wr_en  = 1'b0;
    res_commit = 1'b1; res_ctx = 1'b1; res_seq = 1'b0;
    set_slot(2'd2, 2'b01);
    res_commit = 1'b0;
    check("snd_w0_en", dout_en, 1);
    check("snd_w0", dout, 0);
    check("snd_ctx", dout_ctx_num, 1);
    check("snd_seq", dout_seq_num, 0);
    check("snd_res_ready", res_ready, 0);
    check("snd_in_ready", ready, 4'b1011);
    for (int i = 1; i < 8; i++) begin
      res_wr_en  = (i == 1);
      res_wr_addr = 3'd5;
      res_din    = 64'hFF;
      res_commit = (i == 2);
      res_ctx    = 1'b0;
      res_seq    = 1'b1;
      blk_ack    = (i == 3);
      blk_done   = (i == 5);
      tick();
      res_wr_en = 1'b0; res_commit = 1'b0; blk_ack = 1'b0; blk_done = 1'b0;
      check($sformatf("snd_w%0d", i), dout, 64'(i));
      check($sformatf("snd_en%0d", i), dout_en, 1);
      check($sformatf("snd_ctx%0d", i), {dout_ctx_num, dout_seq_num}, 2'b10);
      if (i == 1) begin
        check("snd_blk_valid", blk_valid, 1);
        check("snd_blk_slot", blk_slot, 2);
      end
      if (i == 5) begin
        check("snd_blk_freed", ready, 4'b1111);
      end
    end
    tick();
    check("snd_end_en", dout_en, 0);
    check("snd_end_res_ready", res_ready, 1);
    check("snd_end_err", err, ERR_EN);

    // reset during SEND word 3
    do_reset();
    for (int i = 0; i < 8; i++) begin
      res_wr_en   = 1'b1;
      res_wr_addr = 3'(i);
      res_din     = 64'h11 * 64'(i);
      tick();
    end
    res_wr_en  = 1'b0;
    res_commit = 1'b1; res_ctx = 1'b0; res_seq = 1'b1;
    tick();
    res_commit = 1'b0;
    check("rs_w0_seq", dout_seq_num, 1);
    tick(); tick(); tick();
    check("rs_w3", dout, 64'h33);
    do_reset();
    check("rs_dout_en", dout_en, 0);
    check("rs_res_ready", res_ready, 1);
    check("rs_ready", ready, 4'b1111);
    check("rs_seq", dout_seq_num, 0);
    tick();
    check("rs_dout_en2", dout_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/core_io.md
CORE_IO -- requirements
Module: core_io

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 64, meaning data word width.
REQ-002 SHALL have parameter BLK_OP_W, default 2, meaning block-operation field width.
REQ-003 SHALL have port CLK, input, 1, the single clock; reset is synchronous and active-high.
REQ-004 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-005 SHALL have port wr_en / wr_addr / din, input, 1 / 4 / MEM_WIDTH, engine-side input word write.
REQ-006 SHALL have port input_ctx / input_seq, input, 1 / 1, slot select s={input_ctx,input_seq}.
REQ-007 SHALL have port set_input_ready / blk_op, input, 1 / BLK_OP_W, marking the selected slot full and giving its op.
REQ-008 SHALL have port ready, output, 4, bit s=1 meaning slot s is empty.
REQ-009 SHALL have ports blk_valid, blk_slot[1:0] and blk_op_out[BLK_OP_W-1:0] as outputs, plus blk_ack as input, for block dispatch to the datapath.
REQ-010 SHALL have ports blk_rd_addr[3:0] as input, blk_rd_data[MEM_WIDTH-1:0] as output and blk_done as input, for datapath reads of the acked slot.
REQ-011 SHALL have ports res_wr_en, res_wr_addr[2:0], res_din[MEM_WIDTH-1:0], res_commit, res_ctx and res_seq as inputs, and res_ready as output, for result write.
REQ-012 SHALL have ports dout_en, dout_seq_num and dout_ctx_num as 1-bit outputs and dout[MEM_WIDTH-1:0] as output, for result return to the engine.
REQ-013 SHALL have port err, output, 1, sticky protocol error.

Function
REQ-014 Input buffer SHALL be 4 slots x 16 words; a wr_en with ready[s]=1 writes din into slot s, word wr_addr.
REQ-015 A wr_en with ready[s]=0 SHALL be dropped; the slot contents stay unchanged.
REQ-016 set_input_ready with ready[s]=1 SHALL clear ready[s] on the next cycle and latch blk_op for slot s.
REQ-017 set_input_ready with ready[s]=0 SHALL be dropped.
REQ-018 Dispatch FSM SHALL have states IDLE, OFFER and BUSY.
REQ-019 In IDLE, the FSM SHALL pick the first full, undispatched slot in round-robin order starting at last_served+1, then go to OFFER.
REQ-020 In OFFER, blk_valid=1 with blk_slot and blk_op_out held stable until blk_ack; blk_ack SHALL move the FSM to BUSY.
REQ-021 Earliest blk_valid SHALL be 2 cycles after set_input_ready.
REQ-022 In BUSY, blk_rd_data SHALL return word blk_rd_addr of the acked slot with 1-cycle latency.
REQ-023 blk_done in BUSY SHALL set ready[slot]=1 on the next cycle, update last_served, and return the FSM to IDLE.
REQ-024 blk_done outside BUSY SHALL be ignored.
REQ-025 blk_done and set_input_ready on the same slot in the same cycle: the slot ends with ready=1 and the set_input_ready is treated as an error per REQ-017.
REQ-026 Output buffer SHALL be 8 words; res_wr_en writes res_din at res_wr_addr only while res_ready=1.
REQ-027 res_commit SHALL clear res_ready, latch res_ctx and res_seq, and enter SEND the next cycle.
REQ-028 SEND SHALL assert dout_en for 8 consecutive cycles with dout = word 0..7 in order and dout_ctx_num/dout_seq_num held.
REQ-029 res_ready SHALL return to 1 in the cycle after the last word.
REQ-030 res_commit while res_ready=0 SHALL be ignored.
REQ-031 Input and output paths SHALL operate concurrently and independently.

Reset
REQ-032 RST SHALL force: ready=4'b1111, blk_valid=0, FSM=IDLE, last_served=3, res_ready=1, dout_en=0, dout_seq_num=0, dout_ctx_num=0, err=0.
REQ-033 RST mid-operation SHALL abandon any in-flight block or SEND within one cycle; buffer RAM contents need not clear.

Configuration
REQ-034 Macro CORE_IO_ERR_EN defined: err SHALL set on a dropped wr_en, a dropped set_input_ready, or an ignored res_commit, and clear only on RST.
REQ-035 Macro CORE_IO_ERR_EN undefined: err SHALL be constant 0; drop behaviour is unchanged.

Verification
REQ-036 Write 16 words to slot 2, then set_input_ready -> ready=4'b1011 next cycle, blk_valid=1 with blk_slot=2 two cycles after set_input_ready; blk_rd_addr=5 -> blk_rd_data=word 5 next cycle.
REQ-037 Fill slots 0, 1 and 3, last_served=0 -> dispatch order is 1, 3, 0; each slot's ready bit returns to 1 one cycle after its blk_done.
REQ-038 set_input_ready on slot 1 while ready[1]=0 (CORE_IO_ERR_EN defined) -> err=1 sticky, op not relatched.
REQ-039 Write results 0x0..0x7, res_commit with ctx=1, seq=0 -> 8 cycles of dout_en with dout=0..7, dout_ctx_num=1, dout_seq_num=0; res_ready=1 after.
REQ-040 Same-cycle blk_done and set_input_ready on the BUSY slot -> ready bit ends 1, FSM=IDLE, err=1 only when CORE_IO_ERR_EN is defined.
REQ-041 Assert RST during SEND word 3 -> dout_en=0 and res_ready=1 next cycle; ready=4'b1111.
